spike_aer_encoder: RTL and testbench

//  Collects the spike outputs of a neuron layer once per timestep and serialises them into

---
 rtl/spike_aer_encoder.sv | 107 ++++++++++
 tb/tb_spike_aer_encoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spike_aer_encoder.sv
// Samples a layer's spike vector on each timestep tick and serialises the set bits as
// ascending AER addresses over a valid/ready stream, marking the final beat of each timestep.
module spike_aer_encoder #(
    parameter int NUM_NEURONS = 16,
    parameter int DROP_W      = 8,
    localparam int ADDR_W     = $clog2(NUM_NEURONS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_NEURONS-1:0] spike_i,
    input  logic                   tick_i,
    output logic                   aer_valid_o,
    input  logic                   aer_ready_i,
    output logic [ADDR_W-1:0]      aer_addr_o,
    output logic                   aer_last_o,
    output logic                   aer_empty_o,
    output logic                   busy_o,
    output logic [DROP_W-1:0]      drop_cnt_o
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [NUM_NEURONS-1:0] ONE = NUM_NEURONS'(1);

    state_t                 state_reg;
    logic [NUM_NEURONS-1:0] pending_reg;
    logic                   valid_reg;
    logic [ADDR_W-1:0]      addr_reg;
    logic                   last_reg;
    logic                   empty_reg;
    logic [DROP_W-1:0]      drop_reg;

    logic                   fire;
    logic                   take_tick;
    logic                   advance;
    logic                   drop_tick;
    logic [NUM_NEURONS-1:0] remaining;
    logic [NUM_NEURONS-1:0] load_vec;
    logic [NUM_NEURONS-1:0] load_onehot;
    logic [ADDR_W-1:0]      load_addr;
    logic                   load_last;
    logic                   load_empty;

    assign fire = valid_reg && aer_ready_i;

    // The beat on the wire is always the lowest set bit, so clearing the lowest set bit
    // of pending_reg removes exactly the address just accepted.
    assign remaining = pending_reg & (pending_reg - ONE);

    // A tick is only honoured when nothing is in flight after this edge: either idle,
    // or the closing beat of the current timestep is being accepted right now.
    assign take_tick = tick_i && ((state_reg == IDLE) || (fire && last_reg));
    assign advance   = fire && !last_reg;
    assign drop_tick = tick_i && (state_reg == SEND) && !take_tick;

    assign load_vec    = take_tick ? spike_i : remaining;
    assign load_onehot = load_vec & (~load_vec + ONE);
    assign load_last   = (load_vec & (load_vec - ONE)) == '0;
    assign load_empty  = load_vec == '0;

    // One-hot to binary: address bit gi is the OR of all one-hot lines whose index has bit gi set.
    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_enc
            logic [NUM_NEURONS-1:0] sel;
            for (genvar gj = 0; gj < NUM_NEURONS; gj++) begin : g_sel
                assign sel[gj] = ((gj >> gi) % 2) == 1;
            end
            assign load_addr[gi] = |(load_onehot & sel);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            valid_reg   <= 1'b0;
            addr_reg    <= '0;
            last_reg    <= 1'b0;
            empty_reg   <= 1'b0;
            drop_reg    <= '0;
        end else begin
            if (take_tick || advance) begin
                state_reg   <= SEND;
                pending_reg <= load_vec;
                valid_reg   <= 1'b1;
                addr_reg    <= load_addr;
                last_reg    <= load_last;
                empty_reg   <= load_empty;
            end else if (fire) begin
                state_reg   <= IDLE;
                pending_reg <= '0;
                valid_reg   <= 1'b0;
            end
            if (drop_tick && (drop_reg != '1)) begin
                drop_reg <= drop_reg + DROP_W'(1);
            end
        end
    end

    assign aer_valid_o = valid_reg;
    assign aer_addr_o  = addr_reg;
    assign aer_last_o  = last_reg;
    assign aer_empty_o = empty_reg;
    assign busy_o      = (state_reg == SEND);
    assign drop_cnt_o  = drop_reg;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: the driver predicts whole timesteps of beats,
// the monitor pops one expectation per handshake and checks per-cycle status outputs.
module tb_spike_aer_encoder;

    localparam int N = 16;

    typedef struct packed {
        logic [3:0] addr;
        logic       last;
        logic       empty;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [N-1:0]  spike_i = '0;
    logic          tick_i = 1'b0;
    logic          aer_valid_o;
    logic          aer_ready_i = 1'b0;
    logic [3:0]    aer_addr_o;
    logic          aer_last_o;
    logic          aer_empty_o;
    logic          busy_o;
    logic [7:0]    drop_cnt_o;

    spike_aer_encoder #(.NUM_NEURONS(N), .DROP_W(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .spike_i     (spike_i),
        .tick_i      (tick_i),
        .aer_valid_o (aer_valid_o),
        .aer_ready_i (aer_ready_i),
        .aer_addr_o  (aer_addr_o),
        .aer_last_o  (aer_last_o),
        .aer_empty_o (aer_empty_o),
        .busy_o      (busy_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    beat_t exp_q[$];
    int    beats_left = 0;
    int    drop_exp   = 0;
    bit    rst_chk    = 0;
    bit    started    = 0;
    int    vec_cnt    = 0;
    int    err_cnt    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a timestep is a list of ascending set-bit indices, or one empty beat.
    task automatic push_timestep(input logic [N-1:0] s);
        int    n;
        int    seen;
        beat_t b;
        n    = $countones(s);
        seen = 0;
        if (n == 0) begin
            b = '{addr: 4'd0, last: 1'b1, empty: 1'b1};
            exp_q.push_back(b);
        end
        for (int i = 0; i < N; i++) begin
            if (s[i]) begin
                seen++;
                b = '{addr: 4'(i), last: (seen == n), empty: 1'b0};
                exp_q.push_back(b);
            end
        end
    endtask

    // Drive one cycle of inputs, then advance the model at the clock edge that samples them.
    task automatic step(input logic t, input logic [N-1:0] s, input logic r, input logic rs);
        bit hs;
        bit last_hs;
        int nb;
        tick_i      = t;
        spike_i     = s;
        aer_ready_i = r;
        rst_i       = rs;
        @(posedge clk_i);
        if (rs) begin
            exp_q.delete();
            beats_left = 0;
            drop_exp   = 0;
            rst_chk    = 1;
            started    = 1;
        end else begin
            hs      = (beats_left > 0) && r;
            last_hs = hs && (beats_left == 1);
            nb      = beats_left - (hs ? 1 : 0);
            if (t) begin
                if (beats_left == 0 || last_hs) begin
                    push_timestep(s);
                    nb = ($countones(s) == 0) ? 1 : $countones(s);
                end else if (drop_exp != 255) begin
                    drop_exp++;
                end
            end
            beats_left = nb;
        end
        #2;
    endtask

    // Monitor: samples mid-cycle, well away from both the clock edge and input updates.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk_i);
            if (started) begin
                if (rst_chk) begin
                    rst_chk = 0;
                    chk("rst_valid", 32'(aer_valid_o), 0);
                    chk("rst_addr",  32'(aer_addr_o),  0);
                    chk("rst_last",  32'(aer_last_o),  0);
                    chk("rst_empty", 32'(aer_empty_o), 0);
                end
                chk("valid", 32'(aer_valid_o), 32'(beats_left > 0));
                chk("busy",  32'(busy_o),      32'(beats_left > 0));
                chk("drop",  32'(drop_cnt_o),  32'(drop_exp));
                if (aer_valid_o === 1'b1 && aer_ready_i === 1'b1 && !rst_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(aer_addr_o), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("addr",  32'(aer_addr_o),  32'(e.addr));
                        chk("last",  32'(aer_last_o),  32'(e.last));
                        chk("empty", 32'(aer_empty_o), 32'(e.empty));
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] s;
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        // Four spikes back to back with ready held high.
        step(1, 16'h8421, 1, 0);
        repeat (6) step(0, 16'hFFFF, 1, 0);

        // Empty timestep.
        step(1, 16'h0000, 1, 0);
        repeat (3) step(0, '0, 1, 0);

        // Backpressure: beats must hold while ready is low.
        step(1, 16'h0006, 0, 0);
        repeat (5) step(0, 16'hFFFF, 0, 0);
        repeat (4) step(0, '0, 1, 0);

        // Ticks during a long stream are dropped; the counter saturates.
        step(1, 16'hFFFF, 1, 0);
        step(1, 16'h0001, 1, 0);
        repeat (300) step(1, 16'h00FF, 0, 0);
        repeat (20) step(0, '0, 1, 0);

        // Tick coincident with the last-beat handshake is taken without a bubble.
        step(1, 16'h0003, 1, 0);
        step(0, '0, 1, 0);
        step(1, 16'h0100, 1, 0);
        repeat (3) step(0, '0, 1, 0);

        // Reset mid-stream, then a fresh single-beat timestep.
        step(1, 16'h00F0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 1);
        step(1, 16'h0001, 1, 0);
        repeat (3) step(0, '0, 1, 0);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(3))
                0: s = '0;
                1: s = N'($urandom) & N'($urandom) & N'($urandom);
                default: s = N'($urandom);
            endcase
            step(($urandom_range(5) == 0), s, ($urandom_range(9) < 7),
                 ($urandom_range(499) == 0));
        end

        repeat (40) step(0, '0, 1, 0);
        chk("drained_queue", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
